coeff_mul_pipe: RTL and testbench
=================================

// Module: coeff_mul_pipe
// PURPOSE
// - Pipelined signed 32x32->64 coefficient multiplier with valid/ready on both sides.
// - Sits directly upstream of the Montgomery reduction stage: P_o feeds its 64-bit A_i input.
// - Also tracks position within a polynomial (N coefficients) and flags the last product.
// PARAMETERS
// - PIPE_STAGES  3        registered stages from input to P_o (legal 1..4)
// - N            256      coefficients per polynomial; index counter wraps at N
// - Q            8380417  modulus; only used by the optional range check
// PORTS
// - clk        in   1   clock, all state on rising edge
// - rst_n      in   1   asynchronous active-low reset
// - A_i        in   32  signed coefficient a
// - B_i        in   32  signed operand b (twiddle or coefficient)
// - valid_i    in   1   A_i/B_i valid
// - ready_o    out  1   block can accept this cycle
// - P_o        out  64  signed product a*b
// - valid_o    out  1   P_o valid
// - ready_i    in   1   downstream (reduction) accepts P_o
// - last_o     out  1   P_o is the product of coefficient index N-1
// - idx_o      out  $clog2(N)  input coefficient index of the next accepted operand pair
// - range_err_o out 1   sticky range error (optional feature)
// BEHAVIOUR
// - Reset (async, rst_n=0): all stage-valid bits 0, valid_o=0, last_o=0, P_o=0, idx_o=0,
//   range_err_o=0. ready_o is 1 as soon as reset deasserts. In-flight data is discarded.
// - Accept: transfer when valid_i && ready_o. Output transfer when valid_o && ready_i.
// - Arithmetic: P = $signed(A_i) * $signed(B_i), full 64-bit, exact, no truncation or rounding.
// - Pipeline: PIPE_STAGES stages, each with data, valid and last bits; P_o/valid_o/last_o come from
//   the final stage. Stage k advances if stage k+1 is empty or stage k+1 advances.
//   The final stage advances on ready_i. Bubbles collapse.
// - ready_o = !stage0_valid || stage0_advances. This is a combinational path from ready_i; accepted.
// - Latency: PIPE_STAGES cycles from accept to valid_o with ready_i held 1.
// - Throughput: 1 product/cycle when ready_i=1 throughout.
// - Stall: while valid_o && !ready_i, P_o and last_o are held stable.
//   The upstream stages fill; then ready_o drops. No data is lost or duplicated.
// - Index counter: idx_o increments on each accept, wraps from N-1 to 0.
//   The accepted pair with idx_o==N-1 carries last=1 down the pipe.
// - Simultaneous accept and output on the same cycle: both take effect, occupancy unchanged.
// - valid_i may drop without an accept (no handshake violation checked); idx_o does not change.
// - Mid-operation reset: pipeline flushed, idx_o returns to 0; next accept is index 0.
// CONFIGURATION
// - RANGE_CHECK_EN defined:
//   - On each accept, if A_i <= -Q or A_i >= Q, range_err_o sets to 1 next cycle.
//     It is sticky until reset. The data still flows unchanged.
// - RANGE_CHECK_EN undefined: no compare logic; range_err_o tied 0.
// TESTING
// - Reset then A_i=3, B_i=5, valid_i=1 one cycle, ready_i=1 -> valid_o=1 exactly 3 cycles later,
//   P_o=15, last_o=0.
// - A_i=-8380416, B_i=8380416 -> P_o=-70231372333056; A_i=-2^31, B_i=-2^31 -> P_o=2^62.
// - Stream 256 pairs back-to-back (A_i=i, B_i=2), ready_i=1 -> 256 outputs P_o=2i in order.
//   last_o only on i=255; idx_o back at 0.
// - Stream continuously and hold ready_i=0 for 5 cycles:
//   - ready_o drops after PIPE_STAGES further accepts;
//   - P_o is stable during the stall;
//   - the sequence resumes with no loss or duplication.
// - Drive rst_n=0 asynchronously with 2 items in flight -> valid_o=0 immediately, idx_o=0.
//   After release, the first product has last_o=0 and the index restarts at 0.
// - RANGE_CHECK_EN: A_i=8380417 accepted -> range_err_o=1 next cycle and stays 1.
//   P_o=8380417*B_i still delivered. Without the macro, range_err_o stays 0.

Source files
------------

// File: rtl/coeff_mul_pipe_if.sv
// Operand/product handshake bundle for coeff_mul_pipe.
// master: the side driving operands and accepting products (testbench or host).
// slave : the multiplier itself.
interface coeff_mul_pipe_if #(
  parameter int IDX_W = 8
);
  logic signed [31:0]  A_i;
  logic signed [31:0]  B_i;
  logic                valid_i;
  logic                ready_o;
  logic signed [63:0]  P_o;
  logic                valid_o;
  logic                ready_i;
  logic                last_o;
  logic [IDX_W-1:0]    idx_o;
  logic                range_err_o;

  modport master (
    output A_i, B_i, valid_i, ready_i,
    input  ready_o, P_o, valid_o, last_o, idx_o, range_err_o
  );

  modport slave (
    input  A_i, B_i, valid_i, ready_i,
    output ready_o, P_o, valid_o, last_o, idx_o, range_err_o
  );
endinterface

// File: rtl/coeff_mul_pipe.sv
// coeff_mul_pipe: pipelined signed 32x32->64 coefficient multiplier with
// valid/ready on both sides, feeding the Montgomery reduction stage.
// Tracks the coefficient index within an N-point polynomial and tags the
// product of index N-1 with last.
// Optional feature: define RANGE_CHECK_EN to enable the sticky |A_i| >= Q
// range flag; without it range_err_o is tied low.
module coeff_mul_pipe #(
  parameter int PIPE_STAGES = 3,
  parameter int N           = 256,
  parameter int Q           = 8380417
) (
  input logic             clk,
  input logic             rst_n,
  coeff_mul_pipe_if.slave bus
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 32;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = $clog2(N);
  localparam int LAST   = PIPE_STAGES - 1;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4 || N < 2 || Q < 2) begin : g_bad_param
    $error("coeff_mul_pipe: illegal parameter combination");
  end

  logic signed [PROD_W-1:0] prod_p  [PIPE_STAGES];
  logic signed [PROD_W-1:0] prod_nx [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]   vld_p;
  logic [PIPE_STAGES-1:0]   last_p;
  logic [PIPE_STAGES-1:0]   vld_nx;
  logic [PIPE_STAGES-1:0]   last_nx;
  logic [PIPE_STAGES-1:0]   free;
  logic                     accept;
  logic                     idx_wrap;
  logic [IDX_W-1:0]         idx_q;

  // A stage may load when it is empty or its content moves on; walk from the output back.
  always_comb begin : free_chain
    logic f;
    free = '0;
    f = !vld_p[LAST] || bus.ready_i;
    for (int k = LAST; k >= 0; k--) begin
      if (k != LAST) f = !vld_p[k] || f;
      free[k] = f;
    end
  end

  assign accept   = bus.valid_i && free[0];
  assign idx_wrap = (idx_q == IDX_W'(N - 1));

  // Stage inputs: stage 0 takes the fresh product, later stages take their predecessor.
  always_comb begin
    vld_nx     = '0;
    last_nx    = '0;
    vld_nx[0]  = accept;
    last_nx[0] = idx_wrap;
    prod_nx[0] = PROD_W'(bus.A_i) * PROD_W'(bus.B_i);
    for (int k = 1; k < PIPE_STAGES; k++) begin
      vld_nx[k]  = vld_p[k-1];
      last_nx[k] = last_p[k-1];
      prod_nx[k] = prod_p[k-1];
    end
  end

  // ---- stage boundaries: valid/last control for every stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (free[k]) begin
          vld_p[k]  <= vld_nx[k];
          last_p[k] <= last_nx[k];
        end
      end
    end
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic signed [PROD_W-1:0] prod_q;
    if (k == LAST) begin : g_out
      // Output-stage product; cleared on reset so P_o reads 0 while idle after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      prod_q <= '0;
        else if (free[k] && vld_nx[k])   prod_q <= prod_nx[k];
      end
    end else begin : g_mid
      // Inner-stage product; only loaded with valid data, never reset.
      always_ff @(posedge clk) begin
        if (free[k] && vld_nx[k]) prod_q <= prod_nx[k];
      end
    end
    assign prod_p[k] = prod_q;
  end

  // Coefficient index of the next accepted pair, wrapping at N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      idx_q <= '0;
    else if (accept) idx_q <= idx_wrap ? '0 : idx_q + IDX_W'(1);
  end

`ifdef RANGE_CHECK_EN
  localparam logic signed [DATA_W-1:0] Q_S = DATA_W'(Q);
  logic range_err_q;

  // Sticky flag for any accepted coefficient outside (-Q, Q); data is not altered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_err_q <= 1'b0;
    else if (accept && (bus.A_i <= -Q_S || bus.A_i >= Q_S)) range_err_q <= 1'b1;
  end

  assign bus.range_err_o = range_err_q;
`else
  assign bus.range_err_o = 1'b0;
`endif

  assign bus.ready_o = free[0];
  assign bus.P_o     = prod_p[LAST];
  assign bus.valid_o = vld_p[LAST];
  assign bus.last_o  = last_p[LAST];
  assign bus.idx_o   = idx_q;

endmodule

// File: tb/tb_coeff_mul_pipe.sv
// Testbench for coeff_mul_pipe: randomized and directed operand streams,
// expected products and last flags queued at accept time, compared by an
// independent output monitor.
module tb_coeff_mul_pipe;

  localparam int PIPE_STAGES = 3;
  localparam int N           = 256;
  localparam int Q           = 8380417;
  localparam int IDX_W       = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  coeff_mul_pipe_if #(.IDX_W(IDX_W)) bus ();

  coeff_mul_pipe #(
    .PIPE_STAGES(PIPE_STAGES),
    .N(N),
    .Q(Q)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    longint p;
    bit     last;
  } exp_t;

  exp_t   sbq[$];
  int     tests = 0;
  int     fails = 0;
  int     idx_m = 0;
  int     n_out = 0;
  int     n_last = 0;
  bit     hold = 0;
  longint held_p;
  bit     held_last;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; reports whether the pair was accepted and queues its expectation.
  task automatic cycle(input bit v, input int a, input int b, input bit r, output bit acc);
    @(negedge clk);
    bus.valid_i = v;
    bus.A_i     = a;
    bus.B_i     = b;
    bus.ready_i = r;
    #1;
    acc = v && bus.ready_o && rst_n;
    if (acc) begin
      chk("idx_o_at_accept", {56'd0, bus.idx_o}, idx_m);
      sbq.push_back('{p: longint'(a) * longint'(b), last: (idx_m == N - 1)});
      idx_m = (idx_m + 1) % N;
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 0, 0, 1'b1, acc);
      if (sbq.size() == 0 && !bus.valid_o) break;
    end
    chk("drain_queue_empty", sbq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    sbq.delete();
    idx_m = 0;
    hold = 0;
    #8;
    rst_n = 1'b1;
  endtask

  // Output monitor: compare every transfer against the queue, and check stalls hold data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("stall_valid_held", bus.valid_o, 1);
          chk("stall_P_held", bus.P_o, held_p);
          chk("stall_last_held", bus.last_o, held_last);
        end
        if (bus.valid_o && bus.ready_i) begin
          hold = 0;
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got P=%0d, expected no output", bus.P_o);
          end else begin
            e = sbq.pop_front();
            chk("P_o", bus.P_o, e.p);
            chk("last_o", bus.last_o, e.last);
            n_out++;
            if (bus.last_o) n_last++;
          end
        end else if (bus.valid_o) begin
          hold      = 1;
          held_p    = bus.P_o;
          held_last = bus.last_o;
        end else begin
          hold = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int cnt;
    int lat;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.A_i     = 0;
    bus.B_i     = 0;
    #23 rst_n = 1'b1;
    #1;
    chk("reset_valid_o", bus.valid_o, 0);
    chk("reset_last_o", bus.last_o, 0);
    chk("reset_P_o", bus.P_o, 0);
    chk("reset_idx_o", {56'd0, bus.idx_o}, 0);
    chk("reset_range_err", bus.range_err_o, 0);
    chk("reset_ready_o", bus.ready_o, 1);

    // Single product and its latency
    cycle(1'b1, 3, 5, 1'b1, acc);
    chk("first_accept", acc, 1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 0, 0, 1'b1, acc);
      if (bus.valid_o && lat == 0) lat = k;
    end
    chk("latency", lat, PIPE_STAGES);

    // Extreme operands
    cycle(1'b1, -8380416, 8380416, 1'b1, acc);
    cycle(1'b1, int'(32'h8000_0000), int'(32'h8000_0000), 1'b1, acc);
    cycle(1'b1, int'(32'h7fff_ffff), int'(32'h8000_0000), 1'b1, acc);
    drain();

    // Full polynomial back to back
    do_reset();
    n_out  = 0;
    n_last = 0;
    cnt    = 0;
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, i, 2, 1'b1, acc);
      cnt += int'(acc);
    end
    chk("stream_accepts", cnt, N);
    drain();
    chk("stream_outputs", n_out, N);
    chk("stream_last_count", n_last, 1);
    chk("stream_idx_wrapped", {56'd0, bus.idx_o}, 0);

    // Downstream stall from an empty pipe
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1000 + i, -3, 1'b0, acc);
      cnt += int'(acc);
    end
    chk("stall_accepts", cnt, PIPE_STAGES);
    chk("stall_ready_o_low", bus.ready_o, 0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 2000 + i, 7, 1'b1, acc);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, int'($urandom), int'($urandom),
            $urandom_range(0, 9) < 6, acc);
    end
    drain();

    // Asynchronous reset with items in flight
    cycle(1'b1, 11, 11, 1'b0, acc);
    cycle(1'b1, 12, 12, 1'b0, acc);
    cycle(1'b0, 0, 0, 1'b0, acc);
    cycle(1'b0, 0, 0, 1'b0, acc);
    chk("pre_reset_valid_o", bus.valid_o, 1);
    #2;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    sbq.delete();
    idx_m = 0;
    hold = 0;
    #1;
    chk("async_reset_valid_o", bus.valid_o, 0);
    chk("async_reset_idx_o", {56'd0, bus.idx_o}, 0);
    chk("async_reset_P_o", bus.P_o, 0);
    chk("async_reset_last_o", bus.last_o, 0);
    #8 rst_n = 1'b1;
    cycle(1'b1, 21, 3, 1'b1, acc);
    chk("post_reset_accept", acc, 1);
    drain();

    // Range flag
    chk("range_clear", bus.range_err_o, 0);
    cycle(1'b1, -8380416, 9, 1'b1, acc);
    cycle(1'b1, 8380416, 1, 1'b1, acc);
    cycle(1'b0, 0, 0, 1'b1, acc);
    chk("range_inbound", bus.range_err_o, 0);
    cycle(1'b1, 8380417, -5, 1'b1, acc);
    cycle(1'b0, 0, 0, 1'b1, acc);
`ifdef RANGE_CHECK_EN
    chk("range_set", bus.range_err_o, 1);
`else
    chk("range_tied_low", bus.range_err_o, 0);
`endif
    cycle(1'b1, 4, 4, 1'b1, acc);
    drain();
`ifdef RANGE_CHECK_EN
    chk("range_sticky", bus.range_err_o, 1);
`else
    chk("range_still_low", bus.range_err_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
